// File: rtl/activation_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : activation_stack_ctrl
// Description : Sequencer for the activation stack of the backpropagation
//               datapath. Per training sample it grants the single stack
//               write port to the input module (address 0), then to the
//               forward module (addresses 1..LAYER_MAX), and finally issues
//               descending pair-read addresses LAYER_MAX-1..0, waiting for a
//               bwd_done pulse after each accepted read address.
//
// Ports       : clk, rst               - clock, synchronous active-high reset
//               start                  - one-cycle pulse, begins a sample
//               in_data/valid/ready    - input-module write source
//               fwd_data/valid/ready   - forward-module write source
//               stack_wr_*             - stack write port (data+addr share
//                                        one valid/ready pair)
//               stack_rd_addr*         - pair-read address handshake
//               bwd_layer              - layer being backpropagated
//               bwd_done               - backward module consumed the pair
//               busy                   - not idle
//               sample_done            - pulse after the last backward layer
//
// Revision    : 1.0 - initial release
// ============================================================================
module activation_stack_ctrl #(
  parameter  int NEURON_NUM       = 6,
  parameter  int ACTIVATION_WIDTH = 8,
  parameter  int STACK_ADDR_WIDTH = 10,
  parameter  int LAYER_MAX        = 4,
  localparam int STACK_WIDTH      = NEURON_NUM * ACTIVATION_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  // input-module source
  input  logic [STACK_WIDTH-1:0]      in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  // forward-module source
  input  logic [STACK_WIDTH-1:0]      fwd_data,
  input  logic                        fwd_valid,
  output logic                        fwd_ready,
  // stack write port
  output logic [STACK_WIDTH-1:0]      stack_wr_data,
  output logic [STACK_ADDR_WIDTH-1:0] stack_wr_addr,
  output logic                        stack_wr_valid,
  input  logic                        stack_wr_ready,
  // stack pair-read address port
  output logic [STACK_ADDR_WIDTH-1:0] stack_rd_addr,
  output logic                        stack_rd_addr_valid,
  input  logic                        stack_rd_addr_ready,
  // backward module
  output logic [STACK_ADDR_WIDTH-1:0] bwd_layer,
  input  logic                        bwd_done,
  // status
  output logic                        busy,
  output logic                        sample_done
);

  // Last forward write address and first backward read address.
  localparam logic [STACK_ADDR_WIDTH-1:0] LAST_WR_ADDR  = STACK_ADDR_WIDTH'(LAYER_MAX);
  localparam logic [STACK_ADDR_WIDTH-1:0] FIRST_RD_ADDR = STACK_ADDR_WIDTH'(LAYER_MAX - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_IN    = 3'd1,
    ST_WR_FWD   = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [STACK_ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [STACK_ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                        sample_done_q, sample_done_d;

  // --------------------------------------------------------------------------
  // State and counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      sample_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      sample_done_q <= sample_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    sample_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_WR_IN;
          wr_cnt_d = '0;
        end
      end

      ST_WR_IN: begin
        if (in_valid && stack_wr_ready) begin
          state_d  = ST_WR_FWD;
          wr_cnt_d = STACK_ADDR_WIDTH'(1);
        end
      end

      ST_WR_FWD: begin
        if (fwd_valid && stack_wr_ready) begin
          if (wr_cnt_q == LAST_WR_ADDR) begin
            state_d  = ST_RD_ISSUE;
            rd_cnt_d = FIRST_RD_ADDR;
          end else begin
            wr_cnt_d = wr_cnt_q + STACK_ADDR_WIDTH'(1);
          end
        end
      end

      ST_RD_ISSUE: begin
        // bwd_done here belongs to no outstanding read and is dropped.
        if (stack_rd_addr_ready) begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (bwd_done) begin
          if (rd_cnt_q == '0) begin
            state_d       = ST_IDLE;
            sample_done_d = 1'b1;
          end else begin
            state_d  = ST_RD_ISSUE;
            rd_cnt_d = rd_cnt_q - STACK_ADDR_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: write mux and handshakes are purely combinational so a
  // source's valid reaches the stack (and the stack's ready reaches the
  // source) in the same cycle; nothing on the data path is registered.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready            = 1'b0;
    fwd_ready           = 1'b0;
    stack_wr_data       = '0;
    stack_wr_addr       = '0;
    stack_wr_valid      = 1'b0;
    stack_rd_addr_valid = 1'b0;

    case (state_q)
      ST_WR_IN: begin
        stack_wr_data  = in_data;
        stack_wr_addr  = '0;
        stack_wr_valid = in_valid;
        in_ready       = stack_wr_ready;
      end

      ST_WR_FWD: begin
        stack_wr_data  = fwd_data;
        stack_wr_addr  = wr_cnt_q;
        stack_wr_valid = fwd_valid;
        fwd_ready      = stack_wr_ready;
      end

      ST_RD_ISSUE: begin
        stack_rd_addr_valid = 1'b1;
      end

      default: begin
      end
    endcase
  end

  // rd_cnt is 0 whenever no read phase is in progress, so these read as 0
  // outside RD_ISSUE/RD_WAIT.
  assign stack_rd_addr = rd_cnt_q;
  assign bwd_layer     = rd_cnt_q;
  assign busy          = (state_q != ST_IDLE);
  assign sample_done   = sample_done_q;

endmodule
`default_nettype wire

// File: tb/tb_activation_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_activation_stack_ctrl
// Description : Randomized self-checking bench. Two instances (LAYER_MAX=3
//               and LAYER_MAX=1) share one random stimulus stream. Each is
//               compared every cycle against a model that tracks only a
//               position in the sample's step sequence:
//                 -1            idle
//                 0..L          write of activation vector at address pos
//                 L+1+2j        issue read of address L-1-j
//                 L+2+2j        wait for bwd_done on read j
// Revision    : 1.0 - initial release
// ============================================================================
module tb_activation_stack_ctrl;

  localparam int NN  = 6;
  localparam int AW  = 8;
  localparam int SAW = 10;
  localparam int SW  = NN * AW;
  localparam int NCYC = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic          rst;
  logic          start;
  logic [SW-1:0] in_data;
  logic          in_valid;
  logic [SW-1:0] fwd_data;
  logic          fwd_valid;
  logic          stack_wr_ready;
  logic          stack_rd_addr_ready;
  logic          bwd_done;

  // per-instance outputs
  logic [1:0]     in_ready, fwd_ready, stack_wr_valid, stack_rd_addr_valid;
  logic [1:0]     busy, sample_done;
  logic [SW-1:0]  stack_wr_data [2];
  logic [SAW-1:0] stack_wr_addr [2];
  logic [SAW-1:0] stack_rd_addr [2];
  logic [SAW-1:0] bwd_layer     [2];

  activation_stack_ctrl #(
    .NEURON_NUM(NN), .ACTIVATION_WIDTH(AW), .STACK_ADDR_WIDTH(SAW), .LAYER_MAX(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[0]),
    .fwd_data(fwd_data), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready[0]),
    .stack_wr_data(stack_wr_data[0]), .stack_wr_addr(stack_wr_addr[0]),
    .stack_wr_valid(stack_wr_valid[0]), .stack_wr_ready(stack_wr_ready),
    .stack_rd_addr(stack_rd_addr[0]), .stack_rd_addr_valid(stack_rd_addr_valid[0]),
    .stack_rd_addr_ready(stack_rd_addr_ready),
    .bwd_layer(bwd_layer[0]), .bwd_done(bwd_done),
    .busy(busy[0]), .sample_done(sample_done[0])
  );

  activation_stack_ctrl #(
    .NEURON_NUM(NN), .ACTIVATION_WIDTH(AW), .STACK_ADDR_WIDTH(SAW), .LAYER_MAX(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[1]),
    .fwd_data(fwd_data), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready[1]),
    .stack_wr_data(stack_wr_data[1]), .stack_wr_addr(stack_wr_addr[1]),
    .stack_wr_valid(stack_wr_valid[1]), .stack_wr_ready(stack_wr_ready),
    .stack_rd_addr(stack_rd_addr[1]), .stack_rd_addr_valid(stack_rd_addr_valid[1]),
    .stack_rd_addr_ready(stack_rd_addr_ready),
    .bwd_layer(bwd_layer[1]), .bwd_done(bwd_done),
    .busy(busy[1]), .sample_done(sample_done[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // model state
  int pos        [2];
  bit done_pulse [2];
  int completed  [2];
  int rd_accepts [2];
  int lm_of      [2];

  // Compare one instance's outputs with what its step position implies.
  task automatic check_outputs(input int k);
    int  lm;
    int  r;
    bit  is_wr_in, is_wr_fwd, is_issue;
    logic [SAW-1:0] exp_rd;
    lm        = lm_of[k];
    is_wr_in  = (pos[k] == 0);
    is_wr_fwd = (pos[k] >= 1) && (pos[k] <= lm);
    is_issue  = 1'b0;
    exp_rd    = '0;
    if (pos[k] > lm) begin
      r        = pos[k] - lm - 1;
      is_issue = (r % 2 == 0);
      exp_rd   = SAW'(lm - 1 - r / 2);
    end
    check($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(pos[k] >= 0));
    check($sformatf("sample_done[%0d]", k), 64'(sample_done[k]), 64'(done_pulse[k]));
    check($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(is_wr_in && stack_wr_ready));
    check($sformatf("fwd_ready[%0d]", k), 64'(fwd_ready[k]), 64'(is_wr_fwd && stack_wr_ready));
    check($sformatf("wr_valid[%0d]", k), 64'(stack_wr_valid[k]),
          64'((is_wr_in && in_valid) || (is_wr_fwd && fwd_valid)));
    check($sformatf("rd_valid[%0d]", k), 64'(stack_rd_addr_valid[k]), 64'(is_issue));
    check($sformatf("rd_addr[%0d]", k), 64'(stack_rd_addr[k]), 64'(exp_rd));
    check($sformatf("bwd_layer[%0d]", k), 64'(bwd_layer[k]), 64'(exp_rd));
    if (is_wr_in || is_wr_fwd) begin
      check($sformatf("wr_addr[%0d]", k), 64'(stack_wr_addr[k]), 64'(pos[k]));
      check($sformatf("wr_data[%0d]", k), 64'(stack_wr_data[k]),
            64'(is_wr_in ? in_data : fwd_data));
    end
  endtask

  // Advance one instance's step position across a clock edge.
  task automatic step_model(input int k);
    int lm;
    int r;
    lm            = lm_of[k];
    done_pulse[k] = 1'b0;
    if (rst) begin
      pos[k] = -1;
    end else if (pos[k] < 0) begin
      if (start) pos[k] = 0;
    end else if (pos[k] == 0) begin
      if (in_valid && stack_wr_ready) pos[k] = 1;
    end else if (pos[k] <= lm) begin
      if (fwd_valid && stack_wr_ready) pos[k] = pos[k] + 1;
    end else begin
      r = pos[k] - lm - 1;
      if (r % 2 == 0) begin
        if (stack_rd_addr_ready) begin
          pos[k] = pos[k] + 1;
          rd_accepts[k]++;
        end
      end else if (bwd_done) begin
        if (r / 2 == lm - 1) begin
          pos[k]        = -1;
          done_pulse[k] = 1'b1;
          completed[k]++;
        end else begin
          pos[k] = pos[k] + 1;
        end
      end
    end
  endtask

  initial begin
    lm_of[0] = 3;
    lm_of[1] = 1;
    for (int k = 0; k < 2; k++) begin
      pos[k] = -1; done_pulse[k] = 1'b0; completed[k] = 0; rd_accepts[k] = 0;
    end
    rst = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0;
    fwd_data = '0; fwd_valid = 1'b0; stack_wr_ready = 1'b0;
    stack_rd_addr_ready = 1'b0; bwd_done = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      rst                 = (cyc < 3) || ($urandom_range(0, 299) == 0);
      start               = ($urandom_range(0, 3) == 0);
      in_data             = SW'({$urandom, $urandom});
      fwd_data            = SW'({$urandom, $urandom});
      in_valid            = ($urandom_range(0, 2) != 0);
      fwd_valid           = ($urandom_range(0, 2) != 0);
      stack_wr_ready      = ($urandom_range(0, 3) != 0);
      stack_rd_addr_ready = ($urandom_range(0, 2) != 0);
      bwd_done            = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      check_outputs(0);
      check_outputs(1);
      @(posedge clk);
      step_model(0);
      step_model(1);
      #1;
    end

    // The random run must actually have exercised complete samples.
    check("samples_done_l3", 64'(completed[0] > 10), 64'd1);
    check("samples_done_l1", 64'(completed[1] > 10), 64'd1);
    check("rd_accepts_l3", 64'(rd_accepts[0] >= 3 * completed[0]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/activation_stack_ctrl.md
# activation_stack_ctrl

Sequencer for the activation stack in the backpropagation datapath. For each training sample it gives the stack's single write port first to the input module, for the input activations at address 0. It then gives the port to the forward module, for layer outputs at addresses 1..LAYER_MAX. Finally it issues descending pair-read addresses LAYER_MAX-1..0 to the stack, one per backward layer, pacing each read on a completion pulse from the backward module.

## Interface
- NEURON_NUM, 6, neurons per layer
- ACTIVATION_WIDTH, 8, bits per activation
- STACK_ADDR_WIDTH, 10, stack address width
- LAYER_MAX, 4, weight layers; LAYER_MAX+1 activation vectors per sample; must be ≥1 and ≤ 2^STACK_ADDR_WIDTH-2
- STACK_WIDTH (localparam) = NEURON_NUM*ACTIVATION_WIDTH

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sample
- in_data  in  STACK_WIDTH  input-module activations
- in_valid / in_ready  in / out  1  input-module handshake
- fwd_data  in  STACK_WIDTH  forward-module layer output
- fwd_valid / fwd_ready  in / out  1  forward-module handshake
- stack_wr_data  out  STACK_WIDTH  to stack write data
- stack_wr_addr  out  STACK_ADDR_WIDTH  to stack write address
- stack_wr_valid  out  1  drives both stack data-valid and addr-valid
- stack_wr_ready  in  1  stack write ready (data and addr ready are identical)
- stack_rd_addr  out  STACK_ADDR_WIDTH  pair-read address
- stack_rd_addr_valid / stack_rd_addr_ready  out / in  1  read-address handshake
- bwd_layer  out  STACK_ADDR_WIDTH  index of the layer currently being backpropagated (= stack_rd_addr)
- bwd_done  in  1  one-cycle pulse; backward module has consumed the current pair
- busy  out  1  high in any state other than IDLE
- sample_done  out  1  one-cycle pulse when the last backward layer completes

## Operation
- States: IDLE, WR_IN, WR_FWD, RD_ISSUE, RD_WAIT. Two counters: wr_cnt and rd_cnt, each STACK_ADDR_WIDTH bits.
- IDLE: if start, go to WR_IN with wr_cnt=0. start is ignored in every other state.
- WR_IN: stack_wr_data=in_data, stack_wr_addr=0, stack_wr_valid=in_valid, in_ready=stack_wr_ready. On in handshake: wr_cnt=1, go to WR_FWD.
- WR_FWD: stack_wr_data=fwd_data, stack_wr_addr=wr_cnt, stack_wr_valid=fwd_valid, fwd_ready=stack_wr_ready. On handshake:
  - if wr_cnt==LAYER_MAX: rd_cnt=LAYER_MAX-1, go to RD_ISSUE;
  - else increment wr_cnt.
- RD_ISSUE: stack_rd_addr=rd_cnt, stack_rd_addr_valid=1. On stack_rd_addr_ready, go to RD_WAIT.
- RD_WAIT: stack_rd_addr_valid=0. On bwd_done:
  - if rd_cnt==0: pulse sample_done, go to IDLE;
  - else decrement rd_cnt, go to RD_ISSUE.
- bwd_done outside RD_WAIT is ignored. in_ready and fwd_ready are 0 outside their own states; the inactive source is never acknowledged.
- Write mux, ready outputs and stack_wr_valid are combinational from state and source valid. No data is registered. stack_rd_addr and bwd_layer are rd_cnt.
- No wrap-around: addresses never exceed LAYER_MAX, and rd_cnt never decrements below 0.

## Timing
- Reset values: state IDLE, wr_cnt=0, rd_cnt=0. in_ready=fwd_ready=stack_wr_valid=stack_rd_addr_valid=busy=sample_done=0. stack_wr_addr=0, stack_rd_addr=bwd_layer=0.
- Reset mid-sample returns to IDLE on the next edge and drops all valids and readies. Stack contents are not cleared.
- start at edge N puts the block in WR_IN from N+1; in_ready can be high in cycle N+1.
- At most one stack write per cycle. Back-to-back forward writes are allowed: continuous fwd_valid with stack_wr_ready gives one write per clock.
- The final forward write handshake at edge M puts the block in RD_ISSUE in cycle M+1, with stack_rd_addr_valid=1.
- stack_rd_addr_valid falls the cycle after the read-address handshake.
- A bwd_done at edge K re-issues the next address in cycle K+1.
- sample_done is high for exactly the one cycle following the final bwd_done edge; busy is 0 in that same cycle.
- Minimum sample length: 1 + (LAYER_MAX+1) + 2·LAYER_MAX cycles plus stack and backward latencies.

## Test plan
- Nominal, LAYER_MAX=3: start, then in_data=A, fwd=B,C,D all valid with stack_wr_ready=1 -> writes A@0, B@1, C@2, D@3 on consecutive cycles. Reads then issue at 2, 1, 0, each after a bwd_done. sample_done pulses once; busy returns to 0.
- Source isolation: fwd_valid held high during WR_IN and in_valid held high during WR_FWD -> fwd_ready=0 in WR_IN and in_ready=0 in WR_FWD. No spurious writes occur.
- Backpressure: stack_rd_addr_ready low for 5 cycles -> stack_rd_addr_valid held with stable address 2 until accepted. bwd_done pulses during RD_ISSUE are ignored.
- Gapped forward stream: fwd_valid toggled 1,0,0,1,1 -> addresses 1, 2, 3 are written only on valid cycles, in order.
- Reset mid-read, at rd_cnt=1 -> next cycle state is IDLE, busy=0 and all valids are 0. A fresh start rewrites from address 0.
- LAYER_MAX=1 boundary: 2 writes (addresses 0, 1), then one read at address 0. sample_done follows the first bwd_done.
